bus_uart_tx_slave: RTL and testbench

Bus slave that gives the or1420 SoC bus a memory-mapped UART transmitter. It decodes a 2-word register window and pushes written bytes into a FIFO. A serializer drains the FIFO onto txd_o as 8N1 frames. It sits on the shared bus next to the RAM and print slaves, and its TX line feeds the system UART pin or the simulation UART model.

---
 rtl/bus_uart_tx_slave.sv | 217 +++++++++++++++++++++
 tb/tb_bus_uart_tx_slave.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx_slave.sv
// rtl/bus_uart_tx_slave.sv - memory-mapped UART transmitter bus slave with TX FIFO
module bus_uart_tx_slave #(
  parameter logic [31:0] baseAddr     = 32'h5000_1000,
  parameter int unsigned CLKS_PER_BIT = 645,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] bus_addrData_i,
  input  logic [3:0]  bus_byteEnables_i,
  input  logic [7:0]  bus_burstSize_i,
  input  logic        bus_readNWrite_i,
  input  logic        bus_beginTransaction_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  output logic [31:0] bus_addrData_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  output logic        bus_busy_o,
  output logic        bus_error_o,
  output logic        txd_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    BUS_IDLE, BUS_WRITE, BUS_READ_DATA, BUS_READ_END, BUS_ERROR
  } bus_state_e;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  bus_state_e bus_state_q, bus_state_d;
  tx_state_e  tx_state_q, tx_state_d;

  logic          data_sel_q, data_sel_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          dv_q, dv_d;
  logic          end_q, end_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push, pop;
  logic          fifo_full, fifo_empty;

  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;

  logic          sel;
  logic          tx_active;
  logic [8:0]    level_ext;
  logic [31:0]   status_word;

  // Address bits below the word and the upper byte lanes carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{bus_byteEnables_i[3:1], bus_addrData_i[1:0]};

  assign sel         = bus_beginTransaction_i && (bus_addrData_i[31:3] == baseAddr[31:3]);
  assign fifo_full   = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign tx_active   = (tx_state_q != TX_IDLE);
  assign level_ext   = 9'(level_q);
  assign status_word = {16'b0, level_ext[7:0], 5'b0, tx_active, fifo_empty, fifo_full};

  assign bus_addrData_o       = rdata_q;
  assign bus_dataValid_o      = dv_q;
  assign bus_endTransaction_o = end_q;
  assign bus_error_o          = (bus_state_q == BUS_ERROR);
  assign bus_busy_o           = (bus_state_q == BUS_WRITE) && fifo_full;
  assign txd_o                = (tx_state_q == TX_START) ? 1'b0 :
                                (tx_state_q == TX_DATA)  ? shreg_q[0] : 1'b1;

  // Bus FSM next state: decode, write beat acceptance, two-cycle read response.
  always_comb begin
    bus_state_d = bus_state_q;
    data_sel_d  = data_sel_q;
    rdata_d     = 32'h0;
    dv_d        = 1'b0;
    end_d       = 1'b0;
    push        = 1'b0;
    case (bus_state_q)
      BUS_IDLE: begin
        if (sel) begin
          data_sel_d = ~bus_addrData_i[2];
          if (bus_burstSize_i != 8'h0)  bus_state_d = BUS_ERROR;
          else if (bus_readNWrite_i)    bus_state_d = BUS_READ_DATA;
          else                          bus_state_d = BUS_WRITE;
        end
      end
      BUS_WRITE: begin
        push = data_sel_q && bus_dataValid_i && bus_byteEnables_i[0] && !fifo_full;
        if (bus_endTransaction_i) bus_state_d = BUS_IDLE;
      end
      BUS_READ_DATA: begin
        dv_d        = 1'b1;
        rdata_d     = data_sel_q ? 32'h0 : status_word;
        bus_state_d = BUS_READ_END;
      end
      BUS_READ_END: begin
        end_d       = 1'b1;
        bus_state_d = BUS_IDLE;
      end
      default: bus_state_d = BUS_IDLE;
    endcase
  end

  // Bus FSM and registered read-response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_state_q <= BUS_IDLE;
      data_sel_q  <= 1'b0;
      rdata_q     <= 32'h0;
      dv_q        <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      bus_state_q <= bus_state_d;
      data_sel_q  <= data_sel_d;
      rdata_q     <= rdata_d;
      dv_q        <= dv_d;
      end_q       <= end_d;
    end
  end

  // FIFO storage; contents need no reset since the level gates every read.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus_addrData_i[7:0];
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  // TX FSM next state: start bit, 8 data bits LSB first, stop bit; chains frames from STOP.
  always_comb begin
    tx_state_d = tx_state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = fifo_mem[rd_ptr_q];
          baud_d     = 16'h0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d     = 16'h0;
          bit_d      = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = 16'h0;
          if (bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = 16'h0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            shreg_d    = fifo_mem[rd_ptr_q];
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase
  end

  // TX FSM state, baud counter, bit index and shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      baud_q     <= 16'h0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'h0;
    end else begin
      tx_state_q <= tx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
    end
  end

endmodule

// File: tb/tb_bus_uart_tx_slave.sv
// tb/tb_bus_uart_tx_slave.sv - directed self-checking bench for bus_uart_tx_slave
module tb_bus_uart_tx_slave;

  localparam logic [31:0] BASE = 32'h5000_1000;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] bus_addrData_i;
  logic [3:0]  bus_byteEnables_i;
  logic [7:0]  bus_burstSize_i;
  logic        bus_readNWrite_i;
  logic        bus_beginTransaction_i;
  logic        bus_endTransaction_i;
  logic        bus_dataValid_i;
  logic [31:0] bus_addrData_o;
  logic        bus_endTransaction_o;
  logic        bus_dataValid_o;
  logic        bus_busy_o;
  logic        bus_error_o;
  logic        txd_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  wbuf [0:7];
  logic [7:0]  rd;
  logic [39:0] rw;
  int          rt, prev_t, busy_cycles;

  wire [36:0] outs = {bus_error_o, bus_busy_o, bus_dataValid_o, bus_endTransaction_o,
                      bus_addrData_o, txd_o};

  bus_uart_tx_slave #(
    .baseAddr    (BASE),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .bus_addrData_i        (bus_addrData_i),
    .bus_byteEnables_i     (bus_byteEnables_i),
    .bus_burstSize_i       (bus_burstSize_i),
    .bus_readNWrite_i      (bus_readNWrite_i),
    .bus_beginTransaction_i(bus_beginTransaction_i),
    .bus_endTransaction_i  (bus_endTransaction_i),
    .bus_dataValid_i       (bus_dataValid_i),
    .bus_addrData_o        (bus_addrData_o),
    .bus_endTransaction_o  (bus_endTransaction_o),
    .bus_dataValid_o       (bus_dataValid_o),
    .bus_busy_o            (bus_busy_o),
    .bus_error_o           (bus_error_o),
    .txd_o                 (txd_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected txd samples for one 8N1 frame at 4 clocks per bit, sample 0 = first start cycle.
  function automatic logic [39:0] frame_wave(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] w;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) w[i] = bits[i / 4];
    return w;
  endfunction

  task automatic rx_frame(output logic [7:0] d, output logic [39:0] w, output int t0);
    int n;
    n  = 0;
    w  = '0;
    d  = '0;
    t0 = -1;
    @(negedge clk_i);
    while (txd_o !== 1'b0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) begin
      check("rx_start_timeout", 0, 1);
      return;
    end
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      w[i] = txd_o;
      if (i != 39) @(negedge clk_i);
    end
    for (int b = 0; b < 8; b++) d[b] = w[4 * (b + 1) + 2];
  endtask

  task automatic bus_write(input logic [31:0] addr, input int n, output int busy_cnt);
    int guard;
    busy_cnt = 0;
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b1;
    bus_addrData_i         = addr;
    bus_readNWrite_i       = 1'b0;
    bus_burstSize_i        = 8'h0;
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus_addrData_i    = {24'h0, wbuf[k]};
      bus_dataValid_i   = 1'b1;
      bus_byteEnables_i = 4'hF;
      guard = 0;
      #1;
      while (bus_busy_o && guard < 1000) begin
        busy_cnt++;
        @(negedge clk_i);
        #1;
        guard++;
      end
      if (guard >= 1000) check("busy_timeout", 0, 1);
      @(negedge clk_i);
    end
    bus_dataValid_i      = 1'b0;
    bus_byteEnables_i    = 4'h0;
    bus_addrData_i       = 32'h0;
    bus_endTransaction_i = 1'b1;
    @(negedge clk_i);
    bus_endTransaction_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b1;
    bus_addrData_i         = addr;
    bus_readNWrite_i       = 1'b1;
    bus_burstSize_i        = 8'h0;
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b0;
    bus_readNWrite_i       = 1'b0;
    bus_addrData_i         = 32'h0;
    check({tag, "_t1"}, {bus_endTransaction_o, bus_dataValid_o, bus_addrData_o}, 34'h0);
    @(negedge clk_i);
    check({tag, "_t2"}, {bus_endTransaction_o, bus_dataValid_o, bus_addrData_o}, {2'b01, exp});
    @(negedge clk_i);
    check({tag, "_t3"}, {bus_endTransaction_o, bus_dataValid_o, bus_addrData_o}, {2'b10, 32'h0});
  endtask

  task automatic ignored_write(input logic [31:0] addr, input string tag);
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b1;
    bus_addrData_i         = addr;
    bus_readNWrite_i       = 1'b0;
    #1 check({tag, "_t0"}, outs, 37'h1);
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b0;
    bus_addrData_i         = 32'h0000_0077;
    bus_dataValid_i        = 1'b1;
    bus_byteEnables_i      = 4'hF;
    #1 check({tag, "_t1"}, outs, 37'h1);
    @(negedge clk_i);
    bus_dataValid_i      = 1'b0;
    bus_addrData_i       = 32'h0;
    bus_endTransaction_i = 1'b1;
    #1 check({tag, "_t2"}, outs, 37'h1);
    @(negedge clk_i);
    bus_endTransaction_i = 1'b0;
    #1 check({tag, "_t3"}, outs, 37'h1);
  endtask

  initial begin
    int n;
    logic stayed_high;
    rst_ni                 = 1'b0;
    bus_addrData_i         = 32'h0;
    bus_byteEnables_i      = 4'h0;
    bus_burstSize_i        = 8'h0;
    bus_readNWrite_i       = 1'b0;
    bus_beginTransaction_i = 1'b0;
    bus_endTransaction_i   = 1'b0;
    bus_dataValid_i        = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_outputs", outs, 37'h1);
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus_read(BASE + 32'h4, 32'h0000_0002, "reset_status");

    // 1: single byte 0x41 produces one full 40-cycle frame.
    wbuf[0] = 8'h41;
    fork
      begin
        rx_frame(rd, rw, rt);
        check("t1_frame", rw, frame_wave(8'h41));
        check("t1_byte", rd, 8'h41);
      end
      bus_write(BASE, 1, busy_cycles);
    join
    bus_read(BASE + 32'h4, 32'h0000_0002, "t1_status");

    // 2: six bytes in one transaction overflow the 4-deep FIFO and stall the master.
    for (int k = 0; k < 6; k++) wbuf[k] = 8'h10 + 8'(k);
    fork
      begin
        prev_t = -1;
        for (int f = 0; f < 6; f++) begin
          rx_frame(rd, rw, rt);
          check($sformatf("t2_frame%0d", f), rw, frame_wave(8'h10 + 8'(f)));
          if (f > 0) check($sformatf("t2_gap%0d", f), 64'((rt - prev_t == 40) || (rt - prev_t == 41)), 1);
          prev_t = rt;
        end
      end
      begin
        bus_write(BASE, 6, busy_cycles);
        check("t2_busy_seen", 64'(busy_cycles > 0), 1);
      end
    join
    bus_read(BASE + 32'h4, 32'h0000_0002, "t2_status");

    // 3: status with three bytes queued behind an active frame.
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'h01; wbuf[3] = 8'h80;
    fork
      begin
        for (int f = 0; f < 4; f++) begin
          rx_frame(rd, rw, rt);
          check($sformatf("t3_frame%0d", f), rw, frame_wave(wbuf[f]));
        end
      end
      begin
        bus_write(BASE, 4, busy_cycles);
        bus_read(BASE + 32'h4, 32'h0000_0304, "t3_status_busy");
      end
    join
    bus_read(BASE + 32'h4, 32'h0000_0002, "t3_status_done");

    // 4: burst request is rejected with a one-cycle error pulse.
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b1;
    bus_addrData_i         = BASE;
    bus_readNWrite_i       = 1'b0;
    bus_burstSize_i        = 8'h3;
    @(negedge clk_i);
    bus_beginTransaction_i = 1'b0;
    bus_burstSize_i        = 8'h0;
    bus_addrData_i         = 32'h0;
    check("t4_err_t1", {bus_error_o, bus_busy_o, bus_dataValid_o, bus_endTransaction_o, txd_o}, 5'b10001);
    @(negedge clk_i);
    check("t4_err_t2", {bus_error_o, bus_busy_o, bus_dataValid_o, bus_endTransaction_o, txd_o}, 5'b00001);
    bus_read(BASE + 32'h4, 32'h0000_0002, "t4_status");

    // 5: out-of-window addresses are ignored; STATUS writes and DATA reads are inert.
    ignored_write(BASE + 32'h8, "t5_base8");
    ignored_write(32'h0000_0000, "t5_zero");
    wbuf[0] = 8'hEE;
    bus_write(BASE + 32'h4, 1, busy_cycles);
    bus_read(BASE + 32'h4, 32'h0000_0002, "t5_status");
    bus_read(BASE, 32'h0000_0000, "t5_data_read");

    // 6: reset during data bit 3 forces the line high immediately.
    wbuf[0] = 8'h41;
    bus_write(BASE, 1, busy_cycles);
    n = 0;
    while (txd_o !== 1'b0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("t6_start_seen", 64'(n < 200), 1);
    for (int i = 0; i < 17; i++) @(negedge clk_i);
    check("t6_bit3_low", txd_o, 1'b0);
    rst_ni = 1'b0;
    #1 check("t6_reset_async", outs, 37'h1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    bus_read(BASE + 32'h4, 32'h0000_0002, "t6_status");
    stayed_high = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (txd_o !== 1'b1) stayed_high = 1'b0;
    end
    check("t6_line_idle", stayed_high, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
